dump_sequencer: RTL and testbench

- Sequences the UART sender through a full post-encryption dump: key, plaintext, ciphertext, trace memory, parameter block.
- Driven by one start pulse from the command decoder or the cipher-done logic. It issues one-hot transmit_sel plus a single-cycle transmit_en per section and waits for transmit_done.
- Applies an inter-section gap, guards each section with a timeout, and holds the cipher core off while dumping.
- Sits between the capture control FSM and the sender.

---
 rtl/dump_sequencer.sv | 125 ++++++++++++
 tb/tb_dump_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dump_sequencer.sv
// Walks section_mask lowest bit first: one transmit_en per section, an optional gap after each transmit_done, and a timeout while waiting.
// First transmit_en follows an accepted start by 2 edges; start is ignored while busy, and the only backpressure is waiting for transmit_done.
module dump_sequencer #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 8000000,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [4:0] section_mask,
  input  logic       transmit_done,
  output logic [4:0] transmit_sel,
  output logic       transmit_en,
  output logic       busy,
  output logic       cipher_hold,
  output logic       done,
  output logic       timeout_err,
  output logic [2:0] sections_sent
);
  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT_DONE, GAP, FINISH} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_nx;
  logic [4:0]       pending, pending_nx, sel_nx, lowest;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             en_nx, busy_nx, done_nx, err_nx;
  logic [2:0]       sent_nx;

  // Two's-complement trick isolates the lowest pending section.
  assign lowest      = pending & (~pending + 5'd1);
  assign cipher_hold = busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      pending       <= '0;
      cnt           <= '0;
      transmit_sel  <= '0;
      transmit_en   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
      sections_sent <= '0;
    end else begin
      state         <= state_nx;
      pending       <= pending_nx;
      cnt           <= cnt_nx;
      transmit_sel  <= sel_nx;
      transmit_en   <= en_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      timeout_err   <= err_nx;
      sections_sent <= sent_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    cnt_nx     = cnt;
    sel_nx     = transmit_sel;
    en_nx      = 1'b0;
    busy_nx    = busy;
    done_nx    = 1'b0;
    err_nx     = timeout_err;
    sent_nx    = sections_sent;
    case (state)
      IDLE: begin
        sel_nx = '0;
        if (start) begin
          pending_nx = section_mask;
          busy_nx    = 1'b1;
          err_nx     = 1'b0;
          sent_nx    = '0;
          state_nx   = SCAN;
        end
      end
      SCAN: begin
        if (pending != 5'd0) begin
          sel_nx   = lowest;
          en_nx    = 1'b1;
          state_nx = ISSUE;
        end else begin
          sel_nx   = '0;
          state_nx = FINISH;
        end
      end
      ISSUE: begin
        cnt_nx   = '0;
        state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_nx = cnt + 1'b1;
        // A completion arriving on the timeout cycle still counts as success.
        if (transmit_done) begin
          pending_nx = pending & ~transmit_sel;
          sent_nx    = sections_sent + 3'd1;
          sel_nx     = '0;
          cnt_nx     = '0;
          state_nx   = (GAP_CYCLES == 0) ? SCAN : GAP;
        end else if (cnt == TIMEOUT_LAST) begin
          err_nx     = 1'b1;
          pending_nx = '0;
          sel_nx     = '0;
          state_nx   = FINISH;
        end
      end
      GAP: begin
        sel_nx = '0;
        cnt_nx = cnt + 1'b1;
        if (cnt == GAP_LAST) state_nx = SCAN;
      end
      FINISH: begin
        sel_nx   = '0;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dump_sequencer.sv
// Randomized bench for dump_sequencer: a sender model answers issues, a scoreboard holds the expected section order and end-of-dump results.
module tb_dump_sequencer;
  localparam int GAP  = 4;
  localparam int TMO  = 100;
  localparam int RESP = 20;

  logic       clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic       sender_done = 1'b0, stray_done = 1'b0, transmit_done;
  logic [4:0] section_mask = 5'd0, transmit_sel;
  logic       transmit_en, busy, cipher_hold, done, timeout_err;
  logic [2:0] sections_sent;

  assign transmit_done = sender_done | stray_done;

  dump_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(24)) dut (
    .clk(clk), .rstn(rstn), .start(start), .section_mask(section_mask),
    .transmit_done(transmit_done), .transmit_sel(transmit_sel), .transmit_en(transmit_en),
    .busy(busy), .cipher_hold(cipher_hold), .done(done), .timeout_err(timeout_err),
    .sections_sent(sections_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passes = 0;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  // Scoreboard: expected selects in issue order, and {timeout_err, sections_sent} per dump.
  logic [4:0] exp_sel_q[$];
  logic [3:0] exp_end_q[$];

  bit         silent = 1'b0;
  logic       outstanding = 1'b0, prev_en = 1'b0;
  logic [4:0] issued_sel = 5'd0;
  int         last_en_cyc = 0, last_sdone_cyc = -1, done_cyc = 0;
  int         done_count = 0, busy_cnt = 0, en_count = 0;

  // Sender model: answers each issue RESP cycles later unless silenced.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (transmit_en && rstn && !silent) begin
        repeat (RESP - 1) @(posedge clk);
        #1 sender_done = 1'b1;
        @(posedge clk);
        #1 sender_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues a section or ends a dump.
  initial begin
    logic [4:0] exp_sel;
    logic [3:0] exp_end;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        outstanding    = 1'b0;
        prev_en        = 1'b0;
        last_sdone_cyc = -1;
      end else begin
        if (busy) busy_cnt++;
        if (transmit_en) begin
          en_count++;
          check("en_single_cycle", int'(prev_en), 0);
          check("en_before_done", int'(outstanding), 0);
          check("busy_hold_during_dump", int'({busy, cipher_hold}), 3);
          exp_sel = 5'd0;
          if (exp_sel_q.size() > 0) exp_sel = exp_sel_q.pop_front();
          check("sel_order", int'(transmit_sel), int'(exp_sel));
          // done sampled one edge after it is seen here, then GAP+1 edges to the next issue
          if (last_sdone_cyc >= 0) check("gap_len", cyc - last_sdone_cyc, GAP + 2);
          outstanding = 1'b1;
          issued_sel  = transmit_sel;
          last_en_cyc = cyc;
        end
        if (sender_done && outstanding) begin
          check("sel_held", int'(transmit_sel), int'(issued_sel));
          outstanding    = 1'b0;
          last_sdone_cyc = cyc;
        end
        if (done) begin
          exp_end = 4'hF;
          if (exp_end_q.size() > 0) exp_end = exp_end_q.pop_front();
          check("no_section_skipped", exp_sel_q.size(), 0);
          check("sections_sent", int'(sections_sent), int'(exp_end[2:0]));
          check("timeout_err", int'(timeout_err), int'(exp_end[3]));
          check("idle_at_done", int'({busy, cipher_hold}), 0);
          exp_sel_q.delete();
          outstanding    = 1'b0;
          last_sdone_cyc = -1;
          done_cyc       = cyc;
          done_count++;
        end
        prev_en = transmit_en;
      end
    end
  end

  // Reference: sections leave lowest bit first; a silent sender stalls the first one.
  function automatic int push_exp(input logic [4:0] mask, input bit tmo);
    int n = 0;
    for (int i = 0; i < 5; i++) begin
      if (mask[i]) begin
        if (!tmo || n == 0) exp_sel_q.push_back(5'(1 << i));
        n++;
      end
    end
    if (tmo && n > 0) begin
      exp_end_q.push_back({1'b1, 3'd0});
      return 1;
    end
    exp_end_q.push_back({1'b0, 3'(n)});
    return n;
  endfunction

  task automatic run_dump(input logic [4:0] mask, input bit tmo, input bit noise);
    int s, d0, b0, e0, n, bound;
    n      = push_exp(mask, tmo);
    silent = tmo;
    d0 = done_count; b0 = busy_cnt; e0 = en_count;
    if (noise) begin
      @(posedge clk); #1 stray_done = 1'b1;
      @(posedge clk); #1 stray_done = 1'b0;
    end
    @(posedge clk); #1 section_mask = mask; start = 1'b1; s = cyc;
    @(posedge clk); #1 start = 1'b0; section_mask = 5'($urandom);
    check("start_clears_err", int'(timeout_err), 0);
    check("start_clears_sent", int'(sections_sent), 0);
    check("busy_on_start", int'(busy), 1);
    @(posedge clk); #1;
    check("first_en_latency", int'(transmit_en), int'(mask != 5'd0));
    bound = 3000;
    while (done_count == d0 && bound > 0) begin
      @(posedge clk); #1;
      // busy here means the next edge cannot land in IDLE, so these starts must be ignored
      start      = noise && busy && ($urandom_range(0, 5) == 0);
      stray_done = noise && !outstanding && ($urandom_range(0, 3) == 0);
      bound--;
    end
    start = 1'b0; stray_done = 1'b0;
    check("dump_completes", done_count - d0, 1);
    check("en_count", en_count - e0, n);
    if (mask == 5'd0) begin
      check("empty_done_latency", done_cyc - s, 3);
      check("empty_busy_cycles", busy_cnt - b0, 2);
    end
    if (tmo && mask != 5'd0) check("timeout_latency", done_cyc - last_en_cyc, TMO + 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got cycle %0d expected under 200000", cyc);
    $fatal(1);
  end

  initial begin
    int d0, bound, n;
    #1;
    check("rst_sel", int'(transmit_sel), 0);
    check("rst_en", int'(transmit_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_hold", int'(cipher_hold), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(timeout_err), 0);
    check("rst_sent", int'(sections_sent), 0);
    #20;
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);

    run_dump(5'b11111, 1'b0, 1'b0);
    run_dump(5'b01010, 1'b0, 1'b0);
    run_dump(5'b00000, 1'b0, 1'b0);
    run_dump(5'b00011, 1'b1, 1'b0);
    run_dump(5'b00100, 1'b0, 1'b0);
    run_dump(5'b11111, 1'b0, 1'b1);

    // Reset while the trace section is outstanding.
    silent = 1'b0;
    n = push_exp(5'b11111, 1'b0);
    @(posedge clk); #1 section_mask = 5'b11111; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    bound = 2000;
    while (!(outstanding && issued_sel == 5'b01000) && bound > 0) begin
      @(posedge clk); #1;
      bound--;
    end
    check("reached_trace_section", int'(issued_sel), 5'b01000);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst_sel", int'(transmit_sel), 0);
    check("midrst_en", int'(transmit_en), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_hold", int'(cipher_hold), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(timeout_err), 0);
    check("midrst_sent", int'(sections_sent), 0);
    exp_sel_q.delete();
    exp_end_q.delete();
    d0 = done_count;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (40) @(posedge clk);
    check("no_done_after_reset", done_count - d0, 0);
    run_dump(5'b10110, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) run_dump(5'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    run_dump(5'($urandom), 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
